// File: rtl/conv_pkg.sv
// Shared widths and FSM encoding for the conv_buffer pixel transmit path.
package conv_pkg;

  localparam int unsigned DATA_WIDTH    = 8;
  localparam int unsigned BUFFER_LENGTH = 2000;
  localparam int unsigned MAX_PIXELS    = 4096;
  localparam int unsigned CW            = $clog2(BUFFER_LENGTH);
  localparam int unsigned AW            = $clog2(MAX_PIXELS);
  // Product width wide enough for any cols*rows before the MAX_PIXELS check
  localparam int unsigned PW            = 2 * CW;
  localparam int unsigned FCW           = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry shift-style skid FIFO; slot0 is always the head so head_o is a register.
module pixel_skid_fifo
  import conv_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [FCW-1:0]        count_o
);

  logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
  logic [DATA_WIDTH-1:0] slot1_q, slot1_d;
  logic [FCW-1:0]        cnt_q, cnt_d;
  logic [FCW-1:0]        occ;
  logic                  do_push;
  logic                  do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != FCW'(2)) || do_pop);
  assign occ     = do_pop ? (cnt_q - FCW'(1)) : cnt_q;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = occ;
    if (do_pop) begin
      slot0_d = slot1_q;
    end
    if (do_push) begin
      if (occ == '0) begin
        slot0_d = data_i;
      end else begin
        slot1_d = data_i;
      end
      cnt_d = occ + FCW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign head_o  = slot0_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/pixel_streamer.sv
// Streams a raster frame from synchronous-read memory into conv_buffer, one pixel per clock,
// with a stall-tolerant read credit scheme and sof/eol/eof framing.
module pixel_streamer
  import conv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CW-1:0]         cfg_column_size,
  input  logic [CW-1:0]         cfg_row_size,
  input  logic                  stall,
  output logic                  mem_rd_en,
  output logic [AW-1:0]         mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] out_point,
  output logic                  valid_out,
  output logic [CW-1:0]         frame_column_size,
  output logic                  sof,
  output logic                  eol,
  output logic                  eof,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  state_t                state_q, state_d;
  logic                  rd_en_q, rd_en_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] pix_q, pix_d;
  logic                  vld_q, vld_d;
  logic [CW-1:0]         cols_q, cols_d;
  logic [AW-1:0]         last_q, last_d;
  logic [AW-1:0]         out_cnt_q, out_cnt_d;
  logic [CW-1:0]         col_q, col_d;
  logic                  sof_q, sof_d;
  logic                  eol_q, eol_d;
  logic                  eof_q, eof_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [PW-1:0]         frame_px;
  logic                  cfg_ok;
  logic                  fifo_has;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [FCW-1:0]        fifo_cnt;
  logic [FCW-1:0]        fifo_cnt_nx;
  logic                  emit;
  logic [DATA_WIDTH-1:0] emit_data;
  logic                  credit;
  logic                  last_col;

  assign frame_px = PW'(cfg_column_size) * PW'(cfg_row_size);
  assign cfg_ok   = (cfg_column_size != '0) && (cfg_row_size != '0) &&
                    (frame_px <= PW'(MAX_PIXELS));

  // Bus data is consumed every cycle it is present: emitted directly or parked in the skid FIFO.
  assign fifo_has  = (fifo_cnt != '0);
  assign emit      = !stall && (fifo_has || pend_q);
  assign fifo_pop  = emit && fifo_has;
  assign fifo_push = pend_q && !(emit && !fifo_has);
  assign emit_data = fifo_has ? fifo_head : mem_rd_data;
  assign last_col  = (col_q == (cols_q - CW'(1)));

  always_comb begin
    fifo_cnt_nx = fifo_cnt;
    if (fifo_push && !fifo_pop) begin
      fifo_cnt_nx = fifo_cnt + FCW'(1);
    end else if (fifo_pop && !fifo_push) begin
      fifo_cnt_nx = fifo_cnt - FCW'(1);
    end
  end

  // A new read is allowed only if everything still owed by memory fits in the FIFO under stall.
  assign credit = (fifo_cnt_nx == '0) || ((fifo_cnt_nx == FCW'(1)) && !rd_en_q);

  pixel_skid_fifo u_skid (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .data_i  (mem_rd_data),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .count_o (fifo_cnt)
  );

  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    addr_d    = addr_q;
    pend_d    = rd_en_q;
    pix_d     = emit ? emit_data : pix_q;
    vld_d     = emit;
    cols_d    = cols_q;
    last_d    = last_q;
    out_cnt_d = out_cnt_q;
    col_d     = col_q;
    sof_d     = emit && (out_cnt_q == '0);
    eol_d     = emit && last_col;
    eof_d     = emit && (out_cnt_q == last_q);
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (emit) begin
      if (out_cnt_q != last_q) begin
        out_cnt_d = out_cnt_q + AW'(1);
      end
      col_d = last_col ? '0 : (col_q + CW'(1));
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            state_d   = RUN;
            busy_d    = 1'b1;
            cols_d    = cfg_column_size;
            last_d    = AW'(frame_px - PW'(1));
            rd_en_d   = 1'b1;
            addr_d    = '0;
            out_cnt_d = '0;
            col_d     = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (rd_en_q && (addr_q == last_q)) begin
          state_d = DRAIN;
        end else begin
          addr_d  = rd_en_q ? (addr_q + AW'(1)) : addr_q;
          rd_en_d = credit;
        end
      end
      DRAIN: begin
        if (vld_q && eof_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      pend_q    <= 1'b0;
      pix_q     <= '0;
      vld_q     <= 1'b0;
      cols_q    <= '0;
      last_q    <= '0;
      out_cnt_q <= '0;
      col_q     <= '0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      pend_q    <= pend_d;
      pix_q     <= pix_d;
      vld_q     <= vld_d;
      cols_q    <= cols_d;
      last_q    <= last_d;
      out_cnt_q <= out_cnt_d;
      col_q     <= col_d;
      sof_q     <= sof_d;
      eol_q     <= eol_d;
      eof_q     <= eof_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign mem_rd_en         = rd_en_q;
  assign mem_rd_addr       = addr_q;
  assign out_point         = pix_q;
  assign valid_out         = vld_q;
  assign frame_column_size = cols_q;
  assign sof               = sof_q;
  assign eol               = eol_q;
  assign eof               = eof_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = err_q;

endmodule
